mac_header_extractor: RTL and testbench
=======================================

Name: mac_header_extractor

Overview:
- Sits directly downstream of the MII frame receiver in the MAC_table path.
- Consumes the receiver's state, data, data-valid, change and error outputs, and captures the 48-bit destination and source MAC addresses of each frame.
- At end of frame it qualifies the frame (no error, correct header byte counts) and presents one learn/lookup request to the MAC table over a valid/ready handshake.
- Keeps saturating statistics counters.

Parameters:
- PORT_W, 2, width of the ingress port identifier.
- PORT_ID, 0, constant ingress port number attached to every request.
- CNT_W, 16, width of each statistics counter.

Ports:
- iclk  in  1  system clock; all logic on the rising edge.
- irst  in  1  asynchronous, active-high reset.
- i_state  in  3  receiver state code: 000 no frame, 001 preamble, 010 delimiter, 011 DA, 100 SA, 101 length, 110 data, 111 FCS.
- i_data  in  8  receiver byte, aligned with i_state.
- i_dv  in  1  receiver byte valid.
- i_change  in  1  one-cycle pulse on a receiver state change.
- i_error  in  1  receiver error; may be asserted in any cycle.
- i_req_ready  in  1  MAC table accepts the request.
- o_req_valid  out  1  request pending.
- o_da  out  48  destination MAC; first received byte in bits 47:40.
- o_sa  out  48  source MAC; same byte order as o_da.
- o_port  out  PORT_W  equals PORT_ID.
- o_bcast  out  1  o_da == 48'hFFFF_FFFF_FFFF.
- o_mcast  out  1  bit 40 of o_da (group bit); also 1 for broadcast.
- o_good_cnt  out  CNT_W  requests generated.
- o_err_cnt  out  CNT_W  frames discarded for error.
- o_drop_cnt  out  CNT_W  good frames lost because the request slot was busy.

Behaviour:
Reset:
- Asynchronous. All outputs and internal registers clear to 0; FSM goes to IDLE.
- Reset asserted mid-frame or mid-handshake discards everything. No request is issued after reset release until a full new frame completes.

Capture FSM states: IDLE, HDR, BODY.
- IDLE -> HDR: on i_change=1 with i_state=001. Clears the sticky error flag, the DA/SA shift registers and the byte counters.
- HDR:
  - Each cycle with i_dv=1 and i_state=011 shifts i_data into da_sr (shift left 8) and increments da_cnt (3 bits, saturates at 7).
  - Same rule for i_state=100 into sa_sr / sa_cnt.
  - Moves to BODY on i_change=1 with i_state=101.
- BODY: waits for end of frame.
- End of frame: i_change=1 with i_state=000 while in HDR or BODY. FSM returns to IDLE in the next cycle.
- Sticky error flag: set by i_error=1 in any cycle from the HDR entry through the end-of-frame cycle inclusive.
- Frame good: error flag clear (including i_error in the end-of-frame cycle), da_cnt==6 and sa_cnt==6. Any other condition increments o_err_cnt.
- i_change with i_state=001 while in HDR or BODY means a restarted frame: count one error, then restart capture as on IDLE -> HDR.

Request slot (single entry, independent of the FSM, so capture of the next frame proceeds while a request is pending):
- Good end of frame with slot empty, or with o_req_valid && i_req_ready in the same cycle: load o_da, o_sa, o_bcast, o_mcast and increment o_good_cnt. o_req_valid=1 from the next cycle.
- Good end of frame with o_req_valid=1 and i_req_ready=0: frame dropped, o_drop_cnt increments, held request is unchanged.
- While o_req_valid=1, o_da/o_sa/o_bcast/o_mcast must not change until handshake completion.
- o_req_valid clears in the cycle after o_req_valid && i_req_ready, unless reloaded as above.
- Latency: end-of-frame cycle to o_req_valid is exactly 1 cycle.

Counters:
- Saturate at all-ones. No wrap.

Decomposition:
- Shared package mac_pkg: the receiver state-code constants (NO_FRAME..FCS, 3 bits), MAC_W=48, the BCAST_ADDR constant, and the FSM state typedef.
- The receiver should import the same constants.
- One sub-module is natural: sat_counter (parameter CNT_W; inputs inc, clock, reset), instantiated three times.

Test Plan:
1. Good frame DA 01:02:03:04:05:06, SA 0A:0B:0C:0D:0E:0F, i_req_ready=1 -> one cycle after end of frame: o_req_valid=1, o_da=48'h010203040506, o_sa=48'h0A0B0C0D0E0F, o_bcast=0, o_mcast=1, o_good_cnt=1.
2. Frame with i_error pulsed for one cycle during data -> no request, o_err_cnt=1. Repeat with i_error only in the end-of-frame cycle -> same result.
3. Broadcast DA FF:FF:FF:FF:FF:FF, i_req_ready held 0 for 20 cycles -> o_req_valid stays 1 with stable outputs, o_bcast=1, o_mcast=1. Clears one cycle after ready rises.
4. Second good frame ends while the slot is pending with ready=0 -> o_drop_cnt=1 and the first request is retained. Repeat with ready=1 in that same cycle -> second frame loaded, o_drop_cnt unchanged, o_good_cnt=2.
5. Only 5 DA bytes valid (i_dv low for one DA byte) -> o_err_cnt increments, no request.
6. irst asserted mid-SA, then a good frame -> only the second frame's request appears, with that frame's addresses. Also: counters preloaded near saturation stop at 16'hFFFF.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MII receiver state codes, MAC constants and capture FSM type
package mac_pkg;

    localparam int MAC_W = 48;

    localparam logic [2:0] NO_FRAME  = 3'b000;
    localparam logic [2:0] PREAMBLE  = 3'b001;
    localparam logic [2:0] DELIMITER = 3'b010;
    localparam logic [2:0] DEST_ADDR = 3'b011;
    localparam logic [2:0] SRC_ADDR  = 3'b100;
    localparam logic [2:0] LENGTH    = 3'b101;
    localparam logic [2:0] DATA      = 3'b110;
    localparam logic [2:0] FCS       = 3'b111;

    localparam logic [MAC_W-1:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_HDR,
        CAP_BODY
    } cap_state_t;

    // Group bit is the LSB of the first transmitted address byte.
    function automatic logic is_group(input logic [MAC_W-1:0] addr);
        return addr[MAC_W-8];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mac_header_extractor.sv
// rtl/mac_header_extractor.sv - captures DA/SA per frame and issues one MAC-table request
module mac_header_extractor
    import mac_pkg::*;
#(
    parameter int PORT_W  = 2,
    parameter int PORT_ID = 0,
    parameter int CNT_W   = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [2:0]        i_state,
    input  logic [7:0]        i_data,
    input  logic              i_dv,
    input  logic              i_change,
    input  logic              i_error,
    input  logic              i_req_ready,
    output logic              o_req_valid,
    output logic [MAC_W-1:0]  o_da,
    output logic [MAC_W-1:0]  o_sa,
    output logic [PORT_W-1:0] o_port,
    output logic              o_bcast,
    output logic              o_mcast,
    output logic [CNT_W-1:0]  o_good_cnt,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    cap_state_t       state;
    logic [MAC_W-1:0] da_sr;
    logic [MAC_W-1:0] sa_sr;
    logic [2:0]       da_cnt;
    logic [2:0]       sa_cnt;
    logic             err_flag;

    logic in_frame;
    logic sof;
    logic eof;
    logic restart;
    logic frame_ok;
    logic eof_good;
    logic slot_free;
    logic load;
    logic drop;
    logic err_inc;

    assign in_frame  = (state != CAP_IDLE);
    assign sof       = i_change && (i_state == PREAMBLE);
    assign eof       = i_change && (i_state == NO_FRAME) && in_frame;
    assign restart   = sof && in_frame;
    // i_error in the end-of-frame cycle itself must still spoil the frame.
    assign frame_ok  = !err_flag && !i_error && (da_cnt == 3'd6) && (sa_cnt == 3'd6);
    assign eof_good  = eof && frame_ok;
    assign slot_free = !o_req_valid || i_req_ready;
    assign load      = eof_good && slot_free;
    assign drop      = eof_good && !slot_free;
    assign err_inc   = (eof && !frame_ok) || restart;

    assign o_port = PORT_W'(PORT_ID);

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= CAP_IDLE;
            da_sr    <= '0;
            sa_sr    <= '0;
            da_cnt   <= '0;
            sa_cnt   <= '0;
            err_flag <= 1'b0;
        end else if (sof) begin
            state    <= CAP_HDR;
            da_sr    <= '0;
            sa_sr    <= '0;
            da_cnt   <= '0;
            sa_cnt   <= '0;
            err_flag <= i_error;
        end else begin
            case (state)
                CAP_IDLE: ;
                CAP_HDR: begin
                    if (i_error) err_flag <= 1'b1;
                    if (i_dv && (i_state == DEST_ADDR)) begin
                        da_sr <= {da_sr[MAC_W-9:0], i_data};
                        if (da_cnt != 3'd7) da_cnt <= da_cnt + 3'd1;
                    end
                    if (i_dv && (i_state == SRC_ADDR)) begin
                        sa_sr <= {sa_sr[MAC_W-9:0], i_data};
                        if (sa_cnt != 3'd7) sa_cnt <= sa_cnt + 3'd1;
                    end
                    if (eof) begin
                        state <= CAP_IDLE;
                    end else if (i_change && (i_state == LENGTH)) begin
                        state <= CAP_BODY;
                    end
                end
                CAP_BODY: begin
                    if (i_error) err_flag <= 1'b1;
                    if (eof) state <= CAP_IDLE;
                end
                default: state <= CAP_IDLE;
            endcase
        end
    end

    // The slot is independent of capture so the next frame can be parsed while it is held.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            o_req_valid <= 1'b0;
            o_da        <= '0;
            o_sa        <= '0;
            o_bcast     <= 1'b0;
            o_mcast     <= 1'b0;
        end else if (load) begin
            o_req_valid <= 1'b1;
            o_da        <= da_sr;
            o_sa        <= sa_sr;
            o_bcast     <= (da_sr == BCAST_ADDR);
            o_mcast     <= is_group(da_sr);
        end else if (o_req_valid && i_req_ready) begin
            o_req_valid <= 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .iclk (iclk),
        .irst (irst),
        .inc  (load),
        .cnt  (o_good_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .iclk (iclk),
        .irst (irst),
        .inc  (err_inc),
        .cnt  (o_err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .iclk (iclk),
        .irst (irst),
        .inc  (drop),
        .cnt  (o_drop_cnt)
    );

endmodule

// File: tb/tb_mac_header_extractor.sv
// tb/tb_mac_header_extractor.sv - random and directed frames checked against a frame-level model
module tb_mac_header_extractor;

    localparam int PW  = 2;
    localparam int PID = 2;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          iclk = 1'b0;
    logic          irst;
    logic [2:0]    i_state;
    logic [7:0]    i_data;
    logic          i_dv;
    logic          i_change;
    logic          i_error;
    logic          i_req_ready;
    logic          o_req_valid;
    logic [47:0]   o_da;
    logic [47:0]   o_sa;
    logic [PW-1:0] o_port;
    logic          o_bcast;
    logic          o_mcast;
    logic [CW-1:0] o_good_cnt;
    logic [CW-1:0] o_err_cnt;
    logic [CW-1:0] o_drop_cnt;

    always #5 iclk = ~iclk;

    mac_header_extractor #(.PORT_W(PW), .PORT_ID(PID), .CNT_W(CW)) dut (
        .iclk        (iclk),
        .irst        (irst),
        .i_state     (i_state),
        .i_data      (i_data),
        .i_dv        (i_dv),
        .i_change    (i_change),
        .i_error     (i_error),
        .i_req_ready (i_req_ready),
        .o_req_valid (o_req_valid),
        .o_da        (o_da),
        .o_sa        (o_sa),
        .o_port      (o_port),
        .o_bcast     (o_bcast),
        .o_mcast     (o_mcast),
        .o_good_cnt  (o_good_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    bit          m_valid = 0;
    logic [47:0] m_da = '0;
    logic [47:0] m_sa = '0;
    int          m_good = 0;
    int          m_err  = 0;
    int          m_drop = 0;
    logic [47:0] cur_da;
    logic [47:0] cur_sa;
    // 0 random, 1 held low, 2 held high, 3 high only in the end-of-frame cycle
    int          rdy_mode = 2;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    task automatic check_all();
        logic [7:0] first_byte;
        first_byte = m_da[47:40];
        check_val("req_valid", 64'(o_req_valid), 64'(m_valid));
        check_val("da", 64'(o_da), 64'(m_da));
        check_val("sa", 64'(o_sa), 64'(m_sa));
        check_val("bcast", 64'(o_bcast), 64'(m_da == 48'hFFFF_FFFF_FFFF));
        check_val("mcast", 64'(o_mcast), 64'(first_byte % 2));
        check_val("port", 64'(o_port), 64'(PID));
        check_val("good_cnt", 64'(o_good_cnt), 64'(m_good));
        check_val("err_cnt", 64'(o_err_cnt), 64'(m_err));
        check_val("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
    endtask

    task automatic drive_cycle(input logic [2:0] st, input logic [7:0] d, input logic dv,
                               input logic ch, input logic er, input bit eof, input bit good,
                               input bit rst_frame);
        bit r;
        case (rdy_mode)
            0:       r = ($urandom_range(0, 1) == 1);
            1:       r = 1'b0;
            2:       r = 1'b1;
            default: r = eof;
        endcase
        i_state = st; i_data = d; i_dv = dv; i_change = ch; i_error = er; i_req_ready = r;
        @(posedge iclk);
        if (eof && good) begin
            if (!m_valid || r) begin
                m_valid = 1'b1; m_da = cur_da; m_sa = cur_sa; m_good = sat(m_good);
            end else begin
                m_drop = sat(m_drop);
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if ((eof && !good) || rst_frame) m_err = sat(m_err);
        #1;
        check_all();
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // miss_idx: -1 none, 0..5 DA byte, 6..11 SA byte dropped; err_mode: 0 none, 1 data, 2 eof cycle
    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa, input int miss_idx,
                              input int err_mode, input bit restart);
        bit good;
        int n;
        int k;
        good = (miss_idx < 0) && (err_mode == 0);
        cur_da = da;
        cur_sa = sa;
        drive_idle($urandom_range(1, 2));
        drive_cycle(3'b001, 8'h55, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        if (restart) begin
            drive_cycle(3'b010, 8'hD5, 1'b1, 1'b1, 1'b0, 0, 0, 0);
            for (int i = 0; i < 6; i++)
                drive_cycle(3'b011, 8'($urandom), 1'b1, i == 0, 1'b0, 0, 0, 0);
            for (int i = 0; i < 3; i++)
                drive_cycle(3'b100, 8'($urandom), 1'b1, i == 0, 1'b0, 0, 0, 0);
            drive_cycle(3'b001, 8'h55, 1'b1, 1'b1, 1'b0, 0, 0, 1);
        end
        drive_cycle(3'b001, 8'h55, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive_cycle(3'b001, 8'h55, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive_cycle(3'b010, 8'hD5, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive_cycle(3'b011, da[47-8*i -: 8], miss_idx != i, i == 0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive_cycle(3'b100, sa[47-8*i -: 8], miss_idx != i + 6, i == 0, 1'b0, 0, 0, 0);
        drive_cycle(3'b101, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(3'b101, 8'h2E, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        n = $urandom_range(2, 6);
        k = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++)
            drive_cycle(3'b110, 8'($urandom), 1'b1, i == 0, (err_mode == 1) && (i == k), 0, 0, 0);
        for (int i = 0; i < 4; i++)
            drive_cycle(3'b111, 8'($urandom), 1'b1, i == 0, 1'b0, 0, 0, 0);
        drive_cycle(3'b000, 8'h00, 1'b0, 1'b1, err_mode == 2, 1, good, 0);
    endtask

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [47:0] a_da;
        logic [47:0] a_sa;
        int kind;
        irst = 1'b1;
        i_state = 3'b000; i_data = 8'h00; i_dv = 1'b0; i_change = 1'b0; i_error = 1'b0;
        i_req_ready = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        check_all();
        irst = 1'b0;

        rdy_mode = 2;
        send_frame(48'h010203040506, 48'h0A0B0C0D0E0F, -1, 0, 0);
        check_val("t1_valid", 64'(o_req_valid), 64'd1);
        check_val("t1_da", 64'(o_da), 64'h010203040506);
        check_val("t1_sa", 64'(o_sa), 64'h0A0B0C0D0E0F);
        check_val("t1_bcast", 64'(o_bcast), 64'd0);
        check_val("t1_mcast", 64'(o_mcast), 64'd1);
        check_val("t1_good", 64'(o_good_cnt), 64'd1);

        send_frame(rand_mac(), rand_mac(), -1, 1, 0);
        check_val("t2_err", 64'(o_err_cnt), 64'd1);
        check_val("t2_valid", 64'(o_req_valid), 64'd0);
        send_frame(rand_mac(), rand_mac(), -1, 2, 0);
        check_val("t2b_err", 64'(o_err_cnt), 64'd2);
        check_val("t2b_valid", 64'(o_req_valid), 64'd0);

        rdy_mode = 1;
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_1111_2222, -1, 0, 0);
        drive_idle(20);
        check_val("t3_valid", 64'(o_req_valid), 64'd1);
        check_val("t3_bcast", 64'(o_bcast), 64'd1);
        check_val("t3_mcast", 64'(o_mcast), 64'd1);
        rdy_mode = 2;
        drive_idle(1);
        check_val("t3_clear", 64'(o_req_valid), 64'd0);

        rdy_mode = 1;
        a_da = 48'h0200_0000_00A1;
        a_sa = 48'h0200_0000_00A2;
        send_frame(a_da, a_sa, -1, 0, 0);
        send_frame(rand_mac(), rand_mac(), -1, 0, 0);
        check_val("t4_drop", 64'(o_drop_cnt), 64'd1);
        check_val("t4_keep_da", 64'(o_da), 64'(a_da));
        rdy_mode = 3;
        send_frame(48'h0400_0000_00C1, 48'h0400_0000_00C2, -1, 0, 0);
        check_val("t4_reload_da", 64'(o_da), 64'h040000_0000C1);
        check_val("t4_drop_same", 64'(o_drop_cnt), 64'd1);

        rdy_mode = 2;
        send_frame(rand_mac(), rand_mac(), 2, 0, 0);
        check_val("t5_err", 64'(o_err_cnt), 64'(m_err));
        check_val("t5_valid", 64'(o_req_valid), 64'd0);

        rdy_mode = 1;
        send_frame(rand_mac(), rand_mac(), -1, 0, 0);
        cur_da = rand_mac();
        cur_sa = rand_mac();
        drive_cycle(3'b001, 8'h55, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(3'b010, 8'hD5, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(3'b011, cur_da[47-8*i -: 8], 1'b1, i == 0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(3'b100, cur_sa[47-8*i -: 8], 1'b1, i == 0, 1'b0, 0, 0, 0);
        irst = 1'b1;
        repeat (2) @(posedge iclk);
        m_valid = 0; m_da = '0; m_sa = '0; m_good = 0; m_err = 0; m_drop = 0;
        #1;
        check_all();
        irst = 1'b0;
        for (int i = 3; i < 6; i++) drive_cycle(3'b100, cur_sa[47-8*i -: 8], 1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive_cycle(3'b101, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(3'b110, 8'h11, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(3'b111, 8'h22, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        check_val("t6_no_req", 64'(o_req_valid), 64'd0);
        send_frame(48'h0600_0000_0061, 48'h0600_0000_0062, -1, 0, 0);
        check_val("t6_da", 64'(o_da), 64'h060000_000061);
        check_val("t6_good", 64'(o_good_cnt), 64'd1);

        for (int f = 0; f < 40; f++) begin
            rdy_mode = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            a_da = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : rand_mac();
            case (kind)
                5:       send_frame(a_da, rand_mac(), $urandom_range(0, 11), 0, 0);
                6:       send_frame(a_da, rand_mac(), -1, 1, 0);
                7:       send_frame(a_da, rand_mac(), -1, 2, 0);
                8:       send_frame(a_da, rand_mac(), -1, 0, 1);
                9:       send_frame(a_da, rand_mac(), $urandom_range(0, 11), 0, 1);
                default: send_frame(a_da, rand_mac(), -1, 0, 0);
            endcase
        end

        rdy_mode = 1;
        for (int f = 0; f < CMAX + 2; f++) send_frame(rand_mac(), rand_mac(), -1, 0, 0);
        check_val("sat_drop", 64'(o_drop_cnt), 64'(CMAX));
        rdy_mode = 2;
        for (int f = 0; f < CMAX + 2; f++) send_frame(rand_mac(), rand_mac(), $urandom_range(0, 11), 0, 0);
        check_val("sat_err", 64'(o_err_cnt), 64'(CMAX));
        for (int f = 0; f < CMAX + 2; f++) send_frame(rand_mac(), rand_mac(), -1, 0, 0);
        check_val("sat_good", 64'(o_good_cnt), 64'(CMAX));
        drive_idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
